// File: rtl/des_key_if.sv
// Purpose : handshake bundle between a DES round datapath and the key scheduler.
// Latency : n/a (wires only).
// Backpressure: key_ready from the datapath stalls the subkey stream.
//   master : drives start/mode/key_in/key_ready, observes the subkey stream and status
//   slave  : the key scheduler; consumes start/mode/key_in/key_ready, drives the rest
interface des_key_if;
    logic        start;      // begin a 16-round schedule
    logic        mode;       // 0 = K1..K16, 1 = K16..K1
    logic [64:1] key_in;     // index n = FIPS bit n
    logic        key_ready;  // datapath accepts current subkey
    logic [48:1] key_48;     // index n = PC-2 output bit n
    logic        key_valid;  // key_48/round_idx valid
    logic [4:1]  round_idx;  // presented round, 0..15
    logic        busy;       // scheduler not idle
    logic        done;       // one-cycle pulse after the 16th subkey is accepted

    modport master (
        output start, mode, key_in, key_ready,
        input  key_48, key_valid, round_idx, busy, done
    );

    modport slave (
        input  start, mode, key_in, key_ready,
        output key_48, key_valid, round_idx, busy, done
    );
endinterface

// File: rtl/des_key_scheduler.sv
// Purpose : DES key schedule; streams the 16 PC-2 subkeys in encrypt or decrypt order.
// Latency : first subkey valid 1 cycle after start is accepted; then one subkey per accepted cycle.
// Backpressure: key_valid && !key_ready holds subkey, round index and C/D stable.
//   clk, rst : single clock, synchronous active-high reset
//   key_if   : des_key_if.slave (start/mode/key_in/key_ready in; key_48/key_valid/round_idx/busy/done out)
module des_key_scheduler (
    input  logic     clk,
    input  logic     rst,
    des_key_if.slave key_if
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      r_state;
    state_t      w_state_nxt;
    logic [28:1] r_c;
    logic [28:1] r_d;
    logic [48:1] r_key_48;
    logic [4:1]  r_round_idx;
    logic        r_mode;
    logic        r_done;

    logic        w_busy;
    logic        w_start_acc;
    logic        w_accept;
    logic        w_last;
    logic [28:1] w_c0;
    logic [28:1] w_d0;
    logic [28:1] w_c_load;
    logic [28:1] w_d_load;
    logic [28:1] w_c_step;
    logic [28:1] w_d_step;
    logic [56:1] w_cd_sel;
    logic [48:1] w_pc2;
    logic [5:1]  w_round_n;
    logic        w_one;
    logic        w_unused;

    // Bit positions follow FIPS numbering, so a FIPS "left" rotation
    // (bit i takes old bit i+1) is a shift toward index 1.
    function automatic logic [28:1] rot_half(input logic [28:1] x, input logic right, input logic one);
        case ({right, one})
            2'b01:   rot_half = {x[1],    x[28:2]};
            2'b00:   rot_half = {x[2:1],  x[28:3]};
            2'b11:   rot_half = {x[27:1], x[28]};
            default: rot_half = {x[26:1], x[28:27]};
        endcase
    endfunction

    // Parity bits of the key are intentionally dropped by PC-1.
    assign w_unused = ^{key_if.key_in[8],  key_if.key_in[16], key_if.key_in[24], key_if.key_in[32],
                        key_if.key_in[40], key_if.key_in[48], key_if.key_in[56], key_if.key_in[64]};

    for (genvar g = 0; g < 28; g++) begin : g_pc1
        assign w_c0[g+1] = key_if.key_in[PC1[g]];
        assign w_d0[g+1] = key_if.key_in[PC1[g+28]];
    end

    // Encrypt: next subkey is K(r+2), reached by rotl s[r+2].
    // Decrypt: next subkey is K(15-r), reached by undoing s[16-r]; at r=15 this is s[1],
    // which returns C/D to C0/D0 once the schedule completes.
    assign w_round_n = r_mode ? (5'd16 - {1'b0, r_round_idx}) : ({1'b0, r_round_idx} + 5'd2);
    assign w_one     = (w_round_n == 5'd1) || (w_round_n == 5'd2) ||
                       (w_round_n == 5'd9) || (w_round_n == 5'd16);
    assign w_last    = (r_round_idx == 4'd15);

    assign w_c_load  = key_if.mode ? w_c0 : rot_half(w_c0, 1'b0, 1'b1);
    assign w_d_load  = key_if.mode ? w_d0 : rot_half(w_d0, 1'b0, 1'b1);
    assign w_c_step  = rot_half(r_c, r_mode, w_one);
    assign w_d_step  = rot_half(r_d, r_mode, w_one);
    assign w_cd_sel  = w_start_acc ? {w_d_load, w_c_load} : {w_d_step, w_c_step};

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign w_pc2[g+1] = w_cd_sel[PC2[g]];
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (key_if.start) w_state_nxt = RUN;
            RUN:     if (key_if.key_ready && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_busy      = 1'b0;
        w_start_acc = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: w_start_acc = key_if.start;
            RUN: begin
                w_busy   = 1'b1;
                w_accept = key_if.key_ready;
            end
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c         <= '0;
            r_d         <= '0;
            r_key_48    <= '0;
            r_round_idx <= '0;
            r_mode      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_accept && w_last;
            if (w_start_acc) begin
                r_mode      <= key_if.mode;
                r_c         <= w_cd_sel[28:1];
                r_d         <= w_cd_sel[56:29];
                r_key_48    <= w_pc2;
                r_round_idx <= 4'd0;
            end else if (w_accept) begin
                if (!w_last || r_mode) begin
                    r_c <= w_cd_sel[28:1];
                    r_d <= w_cd_sel[56:29];
                end
                if (!w_last) begin
                    r_key_48    <= w_pc2;
                    r_round_idx <= r_round_idx + 4'd1;
                end
            end
        end
    end

    assign key_if.key_48    = r_key_48;
    assign key_if.key_valid = w_busy;
    assign key_if.round_idx = r_round_idx;
    assign key_if.busy      = w_busy;
    assign key_if.done      = r_done;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Purpose : self-checking bench for des_key_scheduler against a bit-level FIPS key schedule model.
// Latency : n/a.
// Backpressure: bench drives key_ready, including multi-cycle stalls.
module tb_des_key_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [47:0] obs_keys [0:15];
    int   last_cycles;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

    localparam int SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    des_key_if bus_if ();

    des_key_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .key_if (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Hex values are in FIPS order (first digit = bits 1..4); ports index FIPS bit n as [n].
    function automatic logic [64:1] to_port64(input logic [63:0] v);
        logic [64:1] r;
        for (int n = 1; n <= 64; n++) r[n] = v[64-n];
        return r;
    endfunction

    function automatic logic [47:0] from_port48(input logic [48:1] p);
        logic [47:0] v;
        for (int n = 1; n <= 48; n++) v[48-n] = p[n];
        return v;
    endfunction

    // Subkey Kn from first principles: PC-1, cumulative left rotation, PC-2.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int rnd);
        logic [56:1] cd;
        logic [56:1] rot;
        logic [47:0] res;
        int tot;
        tot = 0;
        for (int i = 0; i < rnd; i++) tot += SHIFTS[i];
        for (int i = 1; i <= 56; i++) cd[i] = k[64-PC1[i-1]];
        for (int i = 1; i <= 28; i++) begin
            rot[i]    = cd[((i - 1 + tot) % 28) + 1];
            rot[28+i] = cd[28 + ((i - 1 + tot) % 28) + 1];
        end
        for (int j = 1; j <= 48; j++) res[48-j] = rot[PC2[j-1]];
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one schedule. stall_rnd: hold key_ready low 3 cycles at that round;
    // intrude_rnd: pulse start with another key/mode at that round; abort_rnd: reset
    // at that round; hold: keep start high throughout and leave it high in the done cycle.
    task automatic run_sched(input logic [63:0] k, input logic m, input int stall_rnd,
                             input int intrude_rnd, input int abort_rnd, input logic hold);
        int exp_r;
        int stalls;
        int cyc;
        bit intruded;
        logic [47:0] exp_key;
        exp_r = 0; stalls = 0; cyc = 0; intruded = 0;
        bus_if.key_in    = to_port64(k);
        bus_if.mode      = m;
        bus_if.start     = 1'b1;
        bus_if.key_ready = 1'b1;
        @(negedge clk);
        if (!hold) begin
            bus_if.start  = 1'b0;
            bus_if.key_in = to_port64({$urandom, $urandom});
            bus_if.mode   = 1'($urandom_range(0, 1));
        end
        while (exp_r < 16 && cyc < 64) begin
            if (exp_r == abort_rnd) begin
                rst              = 1'b1;
                bus_if.start     = 1'b1;
                bus_if.key_ready = 1'b1;
                @(negedge clk);
                rst          = 1'b0;
                bus_if.start = 1'b0;
                check("rst_key_valid", 64'(bus_if.key_valid), 64'd0);
                check("rst_busy",      64'(bus_if.busy),      64'd0);
                check("rst_done",      64'(bus_if.done),      64'd0);
                check("rst_key_48",    64'(bus_if.key_48),    64'd0);
                check("rst_round_idx", 64'(bus_if.round_idx), 64'd0);
                @(negedge clk);
                check("rst_no_done",   64'(bus_if.done),      64'd0);
                check("rst_stay_idle", 64'(bus_if.busy),      64'd0);
                return;
            end
            exp_key = ref_subkey(k, m ? 16 - exp_r : exp_r + 1);
            check("key_valid", 64'(bus_if.key_valid), 64'd1);
            check("busy",      64'(bus_if.busy),      64'd1);
            check("done_mid",  64'(bus_if.done),      64'd0);
            check("round_idx", 64'(bus_if.round_idx), 64'(exp_r));
            check("key_48",    64'(from_port48(bus_if.key_48)), 64'(exp_key));
            obs_keys[exp_r] = from_port48(bus_if.key_48);
            if (exp_r == intrude_rnd && !intruded) begin
                bus_if.start  = 1'b1;
                bus_if.key_in = to_port64(~k);
                bus_if.mode   = ~m;
                intruded      = 1'b1;
            end else begin
                bus_if.start = hold;
            end
            if (exp_r == stall_rnd && stalls < 3) begin
                bus_if.key_ready = 1'b0;
                stalls++;
            end else begin
                bus_if.key_ready = 1'b1;
                exp_r++;
            end
            @(negedge clk);
            cyc++;
        end
        last_cycles = cyc;
        check("all_rounds",    64'(exp_r),            64'd16);
        check("done_pulse",    64'(bus_if.done),      64'd1);
        check("end_key_valid", 64'(bus_if.key_valid), 64'd0);
        check("end_busy",      64'(bus_if.busy),      64'd0);
        if (!hold) begin
            @(negedge clk);
            check("done_clear", 64'(bus_if.done), 64'd0);
            check("idle_busy",  64'(bus_if.busy), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] rk;
        logic        rm;
        rst              = 1'b1;
        bus_if.start     = 1'b1;
        bus_if.mode      = 1'b0;
        bus_if.key_in    = to_port64(KEY);
        bus_if.key_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_key_valid", 64'(bus_if.key_valid), 64'd0);
        check("reset_busy",      64'(bus_if.busy),      64'd0);
        check("reset_done",      64'(bus_if.done),      64'd0);
        check("reset_key_48",    64'(bus_if.key_48),    64'd0);
        check("reset_round_idx", 64'(bus_if.round_idx), 64'd0);
        rst          = 1'b0;
        bus_if.start = 1'b0;
        @(negedge clk);

        // Known-answer encrypt schedule, continuous ready.
        run_sched(KEY, 1'b0, -1, -1, -1, 1'b0);
        check("enc_r0",      64'(obs_keys[0]),  64'h1B02EFFC7072);
        check("enc_r1",      64'(obs_keys[1]),  64'h79AED9DBC9E5);
        check("enc_r15",     64'(obs_keys[15]), 64'hCB3D8B0E17F5);
        check("enc_latency", 64'(last_cycles),  64'd16);

        // Known-answer decrypt schedule.
        run_sched(KEY, 1'b1, -1, -1, -1, 1'b0);
        check("dec_r0",  64'(obs_keys[0]),  64'hCB3D8B0E17F5);
        check("dec_r14", 64'(obs_keys[14]), 64'h79AED9DBC9E5);
        check("dec_r15", 64'(obs_keys[15]), 64'h1B02EFFC7072);

        // Stall at round 4, then a start intrusion at round 7.
        run_sched({$urandom, $urandom}, 1'b0, 4, -1, -1, 1'b0);
        check("stall_cycles", 64'(last_cycles), 64'd19);
        run_sched({$urandom, $urandom}, 1'b0, -1, 7, -1, 1'b0);
        run_sched({$urandom, $urandom}, 1'b1, -1, 7, -1, 1'b0);

        // Reset at round 9, then a fresh schedule must start at K1.
        run_sched({$urandom, $urandom}, 1'b0, -1, -1, 9, 1'b0);
        run_sched(KEY, 1'b0, -1, -1, -1, 1'b0);
        check("post_rst_k1", 64'(obs_keys[0]), 64'h1B02EFFC7072);

        // Start held high: the next schedule begins in the done cycle.
        run_sched({$urandom, $urandom}, 1'b0, -1, -1, -1, 1'b1);
        run_sched({$urandom, $urandom}, 1'b1, -1, -1, -1, 1'b0);

        // Random keys, modes and stall points.
        for (int i = 0; i < 6; i++) begin
            rk = {$urandom, $urandom};
            rm = 1'($urandom_range(0, 1));
            run_sched(rk, rm, int'($urandom_range(0, 15)), -1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_key_scheduler.md
DES_KEY_SCHEDULER -- requirements
Module: des_key_scheduler

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: begin a 16-round schedule for key_in/mode.
REQ-004 SHALL have port mode, input, 1 bit: 0 = encrypt order (K1..K16); 1 = decrypt order (K16..K1).
REQ-005 SHALL have port key_in[64:1], input, 64 bits: DES key; index n = FIPS 46-3 bit n; parity bits 8,16..64 ignored.
REQ-006 SHALL have port key_ready, input, 1 bit: round datapath accepts the current subkey.
REQ-007 SHALL have port key_48[48:1], output, 48 bits: current subkey; index n = FIPS PC-2 output bit n.
REQ-008 SHALL have port key_valid, output, 1 bit: key_48 and round_idx are valid.
REQ-009 SHALL have port round_idx[4:1], output, 4 bits: index of the presented round, 0..15.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the 16th subkey is accepted.

Function
REQ-012 SHALL implement FSM states IDLE and RUN.
REQ-013 SHALL hold registers C[28:1] and D[28:1], where key_shftd[28:1] = C and key_shftd[56:29] = D.
REQ-014 SHALL apply standard PC-1 to produce C0/D0 and standard PC-2 to produce key_48 from the shifted C/D.
REQ-015 SHALL use the per-round shift schedule s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for encrypt rounds 1..16.
REQ-016 SHALL accept start only in IDLE (a start in IDLE is "start accepted"); in that cycle it latches mode, loads C/D and key_48, sets round_idx=0, and enters RUN, with key_valid=1 from the next cycle.
REQ-017 SHALL, when mode=0 and start is accepted, load C/D = rotl(PC-1 halves, 1), i.e. K1.
REQ-018 SHALL, when mode=1 and start is accepted, load C/D = PC-1 halves unshifted, i.e. K16.
REQ-019 SHALL treat accept as key_valid && key_ready.
REQ-020 SHALL, on accept with round_idx<15, in mode=0 rotate C and D left by s[round_idx+2], register the new PC-2 value, and increment round_idx, with key_valid staying 1 so subkeys stream back-to-back.
REQ-021 SHALL, on accept with round_idx<15, in mode=1 rotate C and D right by s[17-(round_idx+1)] (sequence 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1), register the new PC-2 value, and increment round_idx, with key_valid staying 1.
REQ-022 SHALL, while key_valid=1 and key_ready=0, hold key_48, round_idx, C and D stable.
REQ-023 SHALL, on accept with round_idx=15, clear key_valid, go to IDLE, and pulse done=1 for exactly the next cycle.
REQ-024 SHALL accept start in the cycle done is high, because the FSM is already in IDLE.
REQ-025 SHALL ignore start while busy=1, with no effect on the current schedule, mode, or key.
REQ-026 SHALL ignore key_in and mode except in the cycle start is accepted.
REQ-027 SHALL, after both a mode=0 and a mode=1 schedule complete, leave C/D equal to C0/D0, because the total rotation is 28.
REQ-028 SHALL, when key_valid=0, keep key_48 at its last value, and SHALL NOT treat that value as meaningful.
REQ-029 SHALL perform all rotations within their 28-bit half, with wrap-around and no carry between C and D.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, force state=IDLE, C=D=0, key_48=0, round_idx=0, key_valid=0, busy=0, and done=0.
REQ-031 SHALL, on a reset mid-schedule, abandon the schedule immediately and SHALL NOT assert done.
REQ-032 SHALL give rst priority over start and key_ready in the same cycle.

Verification
Hex values below are in FIPS bit order: the first hex digit holds bits 1..4.
REQ-033 SHALL cover: key=133457799BBCDFF1, mode=0, key_ready=1 continuously -> 16 consecutive valid cycles; round 0=1B02EFFC7072, round 1=79AED9DBC9E5, round 15=CB3D8B0E17F5; done pulses once; total time 18 cycles from start.
REQ-034 SHALL cover: same key, mode=1 -> round 0=CB3D8B0E17F5, round 14=79AED9DBC9E5, round 15=1B02EFFC7072.
REQ-035 SHALL cover: mode=0 with key_ready low for 3 cycles at round_idx=4 -> key_48 and round_idx stable across those cycles; the sequence resumes unchanged, with no skipped or duplicated round.
REQ-036 SHALL cover: start pulsed at round_idx=7 with a different key and mode -> no effect; the original 16 subkeys complete.
REQ-037 SHALL cover: rst asserted at round_idx=9 -> all outputs 0 the next cycle, no done; a new start then yields the correct K1.
REQ-038 SHALL cover: start held high continuously -> a new schedule begins in the done cycle and key_valid rises the following cycle.
